// File: rtl/harmonic_synth_seq.sv
// Additive harmonic generator: sums NUM_HARM weighted sine partials through one shared ROM port.
// Latency: sample_ready pulses 2*NUM_HARM+1 cycles after an accepted request (1 cycle on the muted-voice path).
// Backpressure: none downstream; requests arriving while busy are dropped, never queued.
module harmonic_synth_seq #(
    parameter int NUM_HARM    = 4,
    parameter int PHASE_W     = 20,
    parameter int ADDR_W      = 10,
    parameter int WEIGHT_W    = 8,
    parameter int WEIGHT_FRAC = 7,
    parameter int OUT_W       = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play_enable,
    input  logic                generate_next,
    input  logic [PHASE_W-1:0]  step_size,
    input  logic                note_start,
    input  logic                wr_en,
    input  logic [2:0]          wr_idx,
    input  logic [WEIGHT_W-1:0] wr_weight,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [15:0]         rom_data,
    output logic [OUT_W-1:0]    harmonic_out,
    output logic                sample_ready,
    output logic                busy
);

    localparam int K_W     = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
    localparam int ACC_W   = 16 + WEIGHT_W + 1 + $clog2(NUM_HARM);
    localparam int HSTEP_W = PHASE_W + 3;
    localparam int PROD_W  = 16 + WEIGHT_W + 1;

    localparam logic [HSTEP_W-1:0]      ALIAS_LIM = HSTEP_W'(1) << (PHASE_W - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));
    localparam logic [WEIGHT_W-1:0]     UNITY_W   = WEIGHT_W'(1 << WEIGHT_FRAC);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_DONE, S_ZERO} state_t;

    state_t                    state_q, state_d;
    logic [K_W-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [HSTEP_W-1:0]        hstep_q, hstep_d;
    logic [PHASE_W-1:0]        step_q, step_d;
    logic [PHASE_W-1:0]        phase_q  [NUM_HARM];
    logic [PHASE_W-1:0]        phase_d  [NUM_HARM];
    logic [WEIGHT_W-1:0]       weight_q [NUM_HARM];
    logic [WEIGHT_W-1:0]       weight_d [NUM_HARM];
    logic [OUT_W-1:0]          harmonic_out_q, harmonic_out_d;
    logic                      sample_ready_q, sample_ready_d;

    logic [WEIGHT_W-1:0]       cur_weight;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_shr;
    logic [OUT_W-1:0]          acc_sat;
    logic                      muted;

    // Select the current harmonic's phase (ROM address) and weight; weight is read live.
    always_comb begin
        rom_addr   = '0;
        cur_weight = '0;
        for (int i = 0; i < NUM_HARM; i++) begin
            if (k_q == K_W'(i)) begin
                rom_addr   = phase_q[i][PHASE_W-1 -: ADDR_W];
                cur_weight = weight_q[i];
            end
        end
    end

    assign prod    = $signed(rom_data) * $signed({1'b0, cur_weight});
    assign muted   = (hstep_q >= ALIAS_LIM);
    assign acc_shr = acc_q >>> WEIGHT_FRAC;

    // Clamp the rescaled sum into the signed output range.
    always_comb begin
        acc_sat = acc_shr[OUT_W-1:0];
        if (acc_shr > SAT_MAX) begin
            acc_sat = SAT_MAX[OUT_W-1:0];
        end else if (acc_shr < SAT_MIN) begin
            acc_sat = SAT_MIN[OUT_W-1:0];
        end
    end

    // Sequencer next state, weight table writes and datapath updates.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        acc_d          = acc_q;
        hstep_d        = hstep_q;
        step_d         = step_q;
        phase_d        = phase_q;
        weight_d       = weight_q;
        harmonic_out_d = harmonic_out_q;
        sample_ready_d = 1'b0;

        for (int i = 0; i < NUM_HARM; i++) begin
            if (wr_en && (wr_idx == 3'(i))) begin
                weight_d[i] = wr_weight;
            end
        end

        if (note_start) begin
            // Abort anything in flight; output register keeps its last sample.
            state_d = S_IDLE;
            k_d     = '0;
            for (int i = 0; i < NUM_HARM; i++) begin
                phase_d[i] = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (generate_next) begin
                        if (play_enable) begin
                            step_d  = step_size;
                            hstep_d = HSTEP_W'(step_size);
                            k_d     = '0;
                            acc_d   = '0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_ZERO;
                        end
                    end
                end
                S_FETCH: begin
                    state_d = S_MAC;
                end
                S_MAC: begin
                    if (!muted) begin
                        acc_d = acc_q + ACC_W'(prod);
                    end
                    // Muted partials still advance so they stay coherent if the pitch drops.
                    for (int i = 0; i < NUM_HARM; i++) begin
                        if (k_q == K_W'(i)) begin
                            phase_d[i] = phase_q[i] + hstep_q[PHASE_W-1:0];
                        end
                    end
                    hstep_d = hstep_q + HSTEP_W'(step_q);
                    if (k_q == K_W'(NUM_HARM - 1)) begin
                        k_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DONE: begin
                    harmonic_out_d = acc_sat;
                    sample_ready_d = 1'b1;
                    state_d        = S_IDLE;
                end
                S_ZERO: begin
                    harmonic_out_d = '0;
                    sample_ready_d = 1'b1;
                    state_d        = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers; reset leaves a pure fundamental at unity weight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            acc_q          <= '0;
            hstep_q        <= '0;
            step_q         <= '0;
            harmonic_out_q <= '0;
            sample_ready_q <= 1'b0;
            for (int i = 0; i < NUM_HARM; i++) begin
                phase_q[i]  <= '0;
                weight_q[i] <= (i == 0) ? UNITY_W : '0;
            end
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            acc_q          <= acc_d;
            hstep_q        <= hstep_d;
            step_q         <= step_d;
            harmonic_out_q <= harmonic_out_d;
            sample_ready_q <= sample_ready_d;
            phase_q        <= phase_d;
            weight_q       <= weight_d;
        end
    end

    assign harmonic_out = harmonic_out_q;
    assign sample_ready = sample_ready_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_harmonic_synth_seq.sv
// Bench for harmonic_synth_seq: random and directed requests scored against a per-sample arithmetic model.
// Expected samples are queued at request time and consumed by an independent monitor on sample_ready.
// The bench ROM answers one cycle after the address, like a synchronous block RAM.
module tb_harmonic_synth_seq;

    localparam int NH = 4;
    localparam int PW = 20;
    localparam int AW = 10;
    localparam int WW = 8;
    localparam int OW = 18;
    localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
    localparam longint OMIN = -(longint'(1) << (OW - 1));

    logic          clk = 1'b0;
    logic          reset;
    logic          play_enable;
    logic          generate_next;
    logic [PW-1:0] step_size;
    logic          note_start;
    logic          wr_en;
    logic [2:0]    wr_idx;
    logic [WW-1:0] wr_weight;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [OW-1:0] harmonic_out;
    logic          sample_ready;
    logic          busy;

    always #5 clk = ~clk;

    harmonic_synth_seq #(
        .NUM_HARM(NH), .PHASE_W(PW), .ADDR_W(AW), .WEIGHT_W(WW), .WEIGHT_FRAC(7), .OUT_W(OW)
    ) dut (
        .clk(clk), .reset(reset), .play_enable(play_enable), .generate_next(generate_next),
        .step_size(step_size), .note_start(note_start), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_weight(wr_weight), .rom_addr(rom_addr), .rom_data(rom_data),
        .harmonic_out(harmonic_out), .sample_ready(sample_ready), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_count = 0;
    int req_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bench ROM: 0 = ramp (data = address), 1 = constant, 2 = random table.
    int rom_mode = 0;
    int rom_const = 0;
    int rom_tab[1024];

    function automatic int rom_val(input int addr);
        case (rom_mode)
            0:       return addr;
            1:       return rom_const;
            default: return rom_tab[addr];
        endcase
    endfunction

    always @(posedge clk) rom_data <= 16'(rom_val(int'(rom_addr)));

    // Reference model state: phases, weights, last produced sample.
    longint        m_phase[NH];
    int            m_weight[NH];
    logic [OW-1:0] m_last;

    function automatic void model_reset_phases();
        for (int k = 0; k < NH; k++) m_phase[k] = 0;
    endfunction

    // One sample: sum of partials at pre-advance phase, harmonic k+1 stepping at (k+1)*step.
    function automatic logic [OW-1:0] model_sample(input longint step);
        longint acc;
        longint hs;
        acc = 0;
        for (int k = 0; k < NH; k++) begin
            hs = longint'(k + 1) * step;
            if (hs < (longint'(1) << (PW - 1)))
                acc += longint'(rom_val(int'(m_phase[k] >> (PW - AW)))) * longint'(m_weight[k]);
            m_phase[k] = (m_phase[k] + hs) % (longint'(1) << PW);
        end
        acc = acc >>> 7;
        if (acc > OMAX) acc = OMAX;
        if (acc < OMIN) acc = OMIN;
        return acc[OW-1:0];
    endfunction

    typedef struct {
        logic [OW-1:0] val;
        int            at;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Monitor: every pulse must match the oldest expected sample, on its expected cycle.
    always @(negedge clk) begin
        if (sample_ready === 1'b1) begin
            ready_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_ready out=%0d required=no pulse", $signed(harmonic_out));
            end else begin
                mon_e = exp_q.pop_front();
                if (harmonic_out !== mon_e.val) begin
                    failures++;
                    $display("FAIL sample_value actual=%0d required=%0d", $signed(harmonic_out), $signed(mon_e.val));
                end
                checks++;
                if (cyc != mon_e.at) begin
                    failures++;
                    $display("FAIL sample_latency actual_cycle=%0d required_cycle=%0d", cyc, mon_e.at);
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [OW-1:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        exp_q.push_back(e);
        m_last = v;
    endtask

    task automatic set_w(input int idx, input int val);
        wr_en = 1'b1;
        wr_idx = 3'(idx);
        wr_weight = 8'(val);
        @(negedge clk);
        wr_en = 1'b0;
        if (idx < NH) m_weight[idx] = val;
    endtask

    task automatic do_note_start();
        note_start = 1'b1;
        @(negedge clk);
        note_start = 1'b0;
        model_reset_phases();
    endtask

    // Waits for idle, issues one request, returns at the negedge after the accepting edge.
    task automatic request(input logic [PW-1:0] st, input bit play, input bit push);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait_timeout", longint'(n < 50), 1);
        generate_next = 1'b1;
        step_size = st;
        play_enable = play;
        req_cyc = cyc;
        if (push) begin
            if (play) push_exp(model_sample(longint'(st)), cyc + 2 * NH + 2);
            else      push_exp('0, cyc + 2);
        end
        @(negedge clk);
        generate_next = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        logic [OW-1:0] keep;
        reset = 1'b0; play_enable = 1'b1; generate_next = 1'b0; note_start = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_weight = '0; step_size = '0;
        for (int i = 0; i < 1024; i++) rom_tab[i] = int'($urandom_range(0, 65535)) - 32768;
        model_reset_phases();
        for (int k = 0; k < NH; k++) m_weight[k] = (k == 0) ? 128 : 0;
        m_last = '0;

        repeat (3) @(negedge clk);
        check("reset_out", harmonic_out, 0);
        check("reset_ready", sample_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_addr", rom_addr, 0);
        reset = 1'b1;
        @(negedge clk);

        // Fundamental ramp: outputs 0..4.
        rom_mode = 0;
        for (int i = 0; i < 5; i++) request(20'h00400, 1'b1, 1'b1);
        drain();
        check("ramp_last", $signed(harmonic_out), 4);

        // Two-partial mix.
        do_note_start();
        set_w(0, 64);
        set_w(1, 64);
        for (int i = 0; i < 4; i++) request(20'h00400, 1'b1, 1'b1);
        drain();
        check("mix_4th", $signed(harmonic_out), 4);

        // Saturation both directions.
        rom_mode = 1;
        rom_const = 32767;
        for (int k = 0; k < NH; k++) set_w(k, 255);
        request(20'h00400, 1'b1, 1'b1);
        drain();
        check("sat_pos", $signed(harmonic_out), 131071);
        rom_const = -32768;
        request(20'h00400, 1'b1, 1'b1);
        drain();
        check("sat_neg", $signed(harmonic_out), -131072);

        // Alias mute: only the fundamental is below half the phase range.
        for (int k = 0; k < NH; k++) set_w(k, 128);
        rom_const = 1000;
        request(20'h40000, 1'b1, 1'b1);
        drain();
        check("alias_mute", $signed(harmonic_out), 1000);

        // Request during busy is dropped.
        rc = ready_count;
        request(20'h00400, 1'b1, 1'b1);
        @(negedge clk);
        generate_next = 1'b1;
        @(negedge clk);
        generate_next = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("busy_req_pulses", ready_count - rc, 1);

        // Muted-voice path leaves phases alone.
        rom_mode = 0;
        do_note_start();
        set_w(0, 128);
        for (int k = 1; k < NH; k++) set_w(k, 0);
        request(20'h00400, 1'b1, 1'b1);
        request(20'h00400, 1'b1, 1'b1);
        drain();
        request(20'h00400, 1'b0, 1'b1);
        drain();
        check("zero_out", $signed(harmonic_out), 0);
        request(20'h00400, 1'b1, 1'b1);
        drain();
        check("after_zero_phase", $signed(harmonic_out), 2);

        // Live weight writes: w0 changed after its MAC, w3 changed before its MAC.
        do_note_start();
        request(20'h00400, 1'b1, 1'b1);
        drain();
        request(20'h00400, 1'b1, 1'b0);
        m_weight[3] = 128;
        push_exp(model_sample(longint'(20'h00400)), req_cyc + 2 * NH + 2);
        @(negedge clk);
        @(negedge clk);
        set_w(0, 0);
        set_w(3, 128);
        drain();
        check("live_weight", $signed(harmonic_out), 5);
        request(20'h00400, 1'b1, 1'b1);
        drain();

        // note_start abort mid-sample.
        keep = m_last;
        rc = ready_count;
        request(20'h00400, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        do_note_start();
        check("abort_busy", busy, 0);
        repeat (15) @(negedge clk);
        check("abort_pulses", ready_count - rc, 0);
        check("abort_hold_out", $signed(harmonic_out), $signed(keep));
        request(20'h00400, 1'b1, 1'b1);
        check("abort_next_addr", rom_addr, 0);
        drain();

        // note_start with a simultaneous request: not accepted.
        rc = ready_count;
        note_start = 1'b1;
        generate_next = 1'b1;
        play_enable = 1'b1;
        @(negedge clk);
        note_start = 1'b0;
        generate_next = 1'b0;
        model_reset_phases();
        check("ns_gen_busy", busy, 0);
        repeat (12) @(negedge clk);
        check("ns_gen_pulses", ready_count - rc, 0);

        // Randomized traffic against the model.
        rom_mode = 2;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                drain();
                set_w(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 9) == 0) begin
                drain();
                do_note_start();
            end
            if ($urandom_range(0, 1) == 0) request(20'($urandom_range(0, 20'h3FFF)), $urandom_range(0, 4) != 0, 1'b1);
            else                           request(20'($urandom), $urandom_range(0, 4) != 0, 1'b1);
        end
        drain();

        // Asynchronous reset mid-sample.
        request(20'h01234, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_out", harmonic_out, 0);
        check("midreset_ready", sample_ready, 0);
        check("midreset_busy", busy, 0);
        check("midreset_addr", rom_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset_phases();
        for (int k = 0; k < NH; k++) m_weight[k] = (k == 0) ? 128 : 0;
        rom_mode = 0;
        request(20'h00400, 1'b1, 1'b1);
        request(20'h00400, 1'b1, 1'b1);
        drain();
        check("post_reset_weights", $signed(harmonic_out), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/harmonic_synth_seq.md
Name: harmonic_synth_seq

Overview:
- Parametrised, time-multiplexed additive harmonic generator for the note player voice path.
- On each sample request, sums NUM_HARM sine partials: harmonic k+1 runs at (k+1)*step_size. Each partial is scaled by a programmable weight.
- Uses one shared external sine ROM port instead of one sine reader per partial.
- Produces one saturated signed sample per request with a ready pulse. Feeds the voice mixer / codec path.

Parameters:
- NUM_HARM, 4, number of harmonics (1..8), index k=0 is the fundamental.
- PHASE_W, 20, phase accumulator and step_size width; phase wraps mod 2^PHASE_W.
- ADDR_W, 10, sine ROM address width; rom_addr = phase[PHASE_W-1 -: ADDR_W].
- WEIGHT_W, 8, unsigned weight width.
- WEIGHT_FRAC, 7, weight fractional bits (128 = 1.0).
- OUT_W, 18, signed output width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- play_enable  in  1  voice enabled.
- generate_next  in  1  sample request pulse, accepted only when busy=0.
- step_size  in  PHASE_W  fundamental phase increment, latched at accept.
- note_start  in  1  clears all phase accumulators.
- wr_en  in  1  weight write strobe.
- wr_idx  in  3  harmonic index to write.
- wr_weight  in  WEIGHT_W  weight value.
- rom_addr  out  ADDR_W  sine ROM address (combinational from current harmonic phase).
- rom_data  in  16  signed full-cycle sine sample, valid 1 cycle after rom_addr.
- harmonic_out  out  OUT_W  signed weighted sum, registered.
- sample_ready  out  1  one-cycle pulse: harmonic_out updated.
- busy  out  1  sequencer active.

Behaviour:
- Reset (reset=0, async):
  - harmonic_out=0, sample_ready=0, busy=0, all phases=0, FSM=IDLE, k=0.
  - weight[0]=128, other weights=0 (pure fundamental).
- FSM states:
  - IDLE: on generate_next with play_enable=1, latch step_size, set hstep=step_size, k=0, acc=0, busy=1, go to FETCH.
    - If play_enable=0: go to ZERO.
  - FETCH: rom_addr driven from phase[k]; next state MAC.
  - MAC:
    - acc += rom_data * weight[k], unless muted.
    - phase[k] += hstep[PHASE_W-1:0]; hstep += step_size; k++.
    - If k was NUM_HARM-1, go to DONE; else go to FETCH.
  - DONE: harmonic_out <= sat(acc >>> WEIGHT_FRAC); sample_ready=1 for this one cycle; busy=0; go to IDLE.
  - ZERO: harmonic_out <= 0; sample_ready=1; phases unchanged; go to IDLE.
- Latency:
  - sample_ready is high in the cycle 2*NUM_HARM+1 edges after the accepting edge (9 for NUM_HARM=4).
  - ZERO path: sample_ready 1 cycle after accept.
  - harmonic_out holds its value between pulses.
- Phase order: each sample uses the pre-advance phase, so the first sample after reset or note_start reads address 0 for every harmonic.
- Anti-alias: harmonic k is muted (contributes 0) when hstep >= 2^(PHASE_W-1). Its phase still advances mod 2^PHASE_W.
- Widths:
  - hstep is PHASE_W+3 bits.
  - acc is signed, 16+WEIGHT_W+1+clog2(NUM_HARM) bits, with no internal overflow.
  - Saturation clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. The shift is arithmetic (floor).
- Handshake:
  - generate_next while busy=1 is ignored, not queued.
  - sample_ready never asserts without a prior accepted request.
- Weights:
  - Written on any cycle with wr_en=1. wr_idx>=NUM_HARM is ignored.
  - Weights are read live in MAC, so a mid-sample write affects only harmonics not yet processed.
- note_start:
  - Takes priority over everything else: clears all phases, returns FSM to IDLE, drops busy.
  - An in-flight sample is aborted with no sample_ready. harmonic_out keeps its old value.
  - If note_start and generate_next arrive together, the request is not accepted.
- Reset mid-sample: immediate return to reset values; no sample_ready.

Test Plan:
- Fundamental ramp:
  - Setup: reset defaults, bench ROM returns rom_data=rom_addr, step_size=0x00400.
  - Stimulus: 5 requests.
  - Required: harmonic_out = 0,1,2,3,4; each sample_ready 9 cycles after accept.
- Two-partial mix:
  - Setup: weight[0]=64, weight[1]=64, others 0; ramp ROM; step_size=0x00400.
  - Required: 4th sample = floor((3*64+6*64)/128) = 4.
- Saturation:
  - Setup: ROM constant 32767, all weights 255.
  - Required: harmonic_out = 131071. Same with ROM -32768 gives -131072.
- Alias mute:
  - Setup: step_size=0x40000, weights all 128, ROM constant 1000.
  - Required: harmonic_out = 1000 (only k=0 unmuted).
- Handshake and ZERO path:
  - Stimulus: second generate_next during busy.
    - Required: ignored, exactly one sample_ready.
  - Stimulus: play_enable=0 then request.
    - Required: sample_ready next cycle with harmonic_out=0, and phase[0] unchanged.
- Abort:
  - Stimulus: note_start at cycle 4 of a sample.
    - Required: busy=0 next cycle, no sample_ready, next sample reads addr 0.
  - Stimulus: reset low mid-sample.
    - Required: all outputs 0 immediately.
